// File: rtl/ts_submit_scheduler_pkg.sv
// Shared types and constants for the TS submit time-slot scheduler.
package ts_submit_scheduler_pkg;

  localparam int ADDR_W    = 5;
  localparam int VALID_BIT = 5;
  localparam int ENTRY_W   = 6;

  localparam logic [31:0] MIN_SLOT_LEN = 32'd8;

  typedef enum logic [2:0] {
    IDLE_S,
    RD1_S,
    RD2_S,
    CHECK_S,
    WAIT_ACK_S
  } sched_state_t;

  function automatic logic [31:0] eff_slot_len(
    input logic [31:0] len
  );
    return (len < MIN_SLOT_LEN) ? MIN_SLOT_LEN : len;
  endfunction

endpackage

// File: rtl/ts_submit_scheduler_if.sv
// Submit-address wr/ack handshake between the scheduler and the TS submit stage.
interface ts_submit_scheduler_if;
  import ts_submit_scheduler_pkg::*;

  logic [ADDR_W-1:0] ov_ts_submit_addr;
  logic              o_ts_submit_addr_wr;
  logic              i_ts_submit_addr_ack;

  modport master (
    output ov_ts_submit_addr,
    output o_ts_submit_addr_wr,
    input  i_ts_submit_addr_ack
  );

  modport slave (
    input  ov_ts_submit_addr,
    input  o_ts_submit_addr_wr,
    output i_ts_submit_addr_ack
  );

endinterface

// File: rtl/ts_sched_table_ram.sv
// Simple dual-port schedule table, two-cycle registered read, no clear.
module ts_sched_table_ram #(
  parameter int AW = 10,
  parameter int DW = 6
) (
  input  logic          i_clk,
  input  logic          i_wr,
  input  logic [AW-1:0] iv_waddr,
  input  logic [DW-1:0] iv_wdata,
  input  logic          i_rden,
  input  logic [AW-1:0] iv_raddr,
  output logic [DW-1:0] ov_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_d1;
  logic [DW-1:0] rd_q;

  // Same-edge write and read of one address returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_wr) mem[iv_waddr] <= iv_wdata;
    if (i_rden) rd_d1 <= mem[iv_raddr];
    rd_q <= rd_d1;
  end

  assign ov_rdata = rd_q;

endmodule

// File: rtl/ts_submit_scheduler.sv
// Time-slot scheduler issuing table submit addresses; TS_SUBMIT_STAT_EN adds counters.
import ts_submit_scheduler_pkg::*;

module ts_submit_scheduler #(
  parameter int SLOT_W     = 10,
  parameter int SLOT_LEN_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sched_en,
  input  logic [SLOT_LEN_W-1:0] iv_slot_len,
  input  logic [SLOT_W-1:0]     iv_last_slot,
  input  logic                  i_cycle_start,
  input  logic [ENTRY_W-1:0]    iv_tbl_wdata,
  input  logic [SLOT_W-1:0]     iv_tbl_waddr,
  input  logic                  i_tbl_wr,
  ts_submit_scheduler_if.master sub,
  output logic [SLOT_W-1:0]     ov_slot_idx,
  output logic                  o_submit_miss_pulse
`ifdef TS_SUBMIT_STAT_EN
  ,
  output logic [31:0]           ov_submit_cnt,
  output logic [31:0]           ov_miss_cnt
`endif
);

  logic [SLOT_LEN_W-1:0] slot_cyc;
  logic [SLOT_W-1:0]     slot_idx;
  logic [31:0]           len_m1;
  logic                  slot_tick;

  sched_state_t          state, state_n;
  logic                  wr_q, wr_n;
  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic                  miss_q, miss_n;
  logic                  rden_q, rden_n;
  logic [SLOT_W-1:0]     raddr_q, raddr_n;
  logic [ENTRY_W-1:0]    rdata;
  logic                  ack_ok;

  assign len_m1    = eff_slot_len(32'(iv_slot_len)) - 32'd1;
  assign slot_tick = i_sched_en && (slot_cyc == '0);
  assign ack_ok    = i_sched_en && (state == WAIT_ACK_S)
                   && sub.i_ts_submit_addr_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_sched_en || i_cycle_start) begin
      slot_cyc <= '0;
      slot_idx <= '0;
    end else if (32'(slot_cyc) >= len_m1) begin
      slot_cyc <= '0;
      slot_idx <= (slot_idx >= iv_last_slot) ? '0 : slot_idx + 1'b1;
    end else begin
      slot_cyc <= slot_cyc + 1'b1;
    end
  end

  ts_sched_table_ram #(
    .AW (SLOT_W),
    .DW (ENTRY_W)
  ) u_tbl (
    .i_clk    (i_clk),
    .i_wr     (i_tbl_wr),
    .iv_waddr (iv_tbl_waddr),
    .iv_wdata (iv_tbl_wdata),
    .i_rden   (rden_q),
    .iv_raddr (raddr_q),
    .ov_rdata (rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE_S;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      miss_q  <= 1'b0;
      rden_q  <= 1'b0;
      raddr_q <= '0;
    end else begin
      state   <= state_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      miss_q  <= miss_n;
      rden_q  <= rden_n;
      raddr_q <= raddr_n;
    end
  end

  // A tick preempts any read or pending request; only a live wait is a miss.
  always_comb begin
    state_n = state;
    wr_n    = wr_q;
    addr_n  = addr_q;
    miss_n  = 1'b0;
    rden_n  = 1'b0;
    raddr_n = raddr_q;
    if (!i_sched_en) begin
      state_n = IDLE_S;
      wr_n    = 1'b0;
      addr_n  = '0;
    end else if (slot_tick) begin
      miss_n  = (state == WAIT_ACK_S) && !ack_ok;
      wr_n    = 1'b0;
      addr_n  = '0;
      rden_n  = 1'b1;
      raddr_n = slot_idx;
      state_n = RD1_S;
    end else begin
      unique case (state)
        IDLE_S:  state_n = IDLE_S;
        RD1_S:   state_n = RD2_S;
        RD2_S:   state_n = CHECK_S;
        CHECK_S: begin
          if (rdata[VALID_BIT]) begin
            wr_n    = 1'b1;
            addr_n  = rdata[ADDR_W-1:0];
            state_n = WAIT_ACK_S;
          end else begin
            state_n = IDLE_S;
          end
        end
        WAIT_ACK_S: begin
          if (ack_ok) begin
            wr_n    = 1'b0;
            addr_n  = '0;
            state_n = IDLE_S;
          end
        end
        default: state_n = IDLE_S;
      endcase
    end
  end

  assign sub.ov_ts_submit_addr   = addr_q;
  assign sub.o_ts_submit_addr_wr = wr_q;
  assign ov_slot_idx             = slot_idx;
  assign o_submit_miss_pulse     = miss_q;

`ifdef TS_SUBMIT_STAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_submit_cnt <= '0;
      ov_miss_cnt   <= '0;
    end else if (i_sched_en) begin
      if (ack_ok) ov_submit_cnt <= ov_submit_cnt + 32'd1;
      if (miss_n) ov_miss_cnt <= ov_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ts_submit_scheduler.sv
// Bench for ts_submit_scheduler: random slot runs against a timeline model plus directed cases.
module tb_ts_submit_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cstart;
  logic        twr;
  logic [15:0] slen;
  logic [9:0]  last;
  logic [9:0]  waddr;
  logic [5:0]  wdata;
  logic [9:0]  slot_idx;
  logic        miss;
`ifdef TS_SUBMIT_STAT_EN
  logic [31:0] sub_cnt;
  logic [31:0] miss_cnt;
`endif

  int vec;
  int errs;
  int exp_sub;
  int exp_miss;

  ts_submit_scheduler_if sif ();

  ts_submit_scheduler dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sched_en          (en),
    .iv_slot_len         (slen),
    .iv_last_slot        (last),
    .i_cycle_start       (cstart),
    .iv_tbl_wdata        (wdata),
    .iv_tbl_waddr        (waddr),
    .i_tbl_wr            (twr),
    .sub                 (sif.master),
    .ov_slot_idx         (slot_idx),
    .o_submit_miss_pulse (miss)
`ifdef TS_SUBMIT_STAT_EN
    ,
    .ov_submit_cnt       (sub_cnt),
    .ov_miss_cnt         (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef TS_SUBMIT_STAT_EN
    chk({tag, "_subcnt"}, int'(sub_cnt), exp_sub);
    chk({tag, "_misscnt"}, int'(miss_cnt), exp_miss);
`else
    chk({tag, "_idle_miss"}, int'(miss), 0);
`endif
  endtask

  bit         tv [8];
  logic [4:0] ta [8];
  int         dl [64];

  initial begin
    int L, N, P, kend;
    int k, ph, s, ps, km1;
    bit hold, hang, e_wr, e_miss, ak;
    int e_addr, e_idx;
    vec = 0; errs = 0; exp_sub = 0; exp_miss = 0;
    rst = 1'b1; en = 1'b0; cstart = 1'b0; twr = 1'b0;
    slen = 16'd8; last = 10'd3; waddr = '0; wdata = '0;
    sif.i_ts_submit_addr_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", int'(sif.o_ts_submit_addr_wr), 0);
    chk("rst_addr", int'(sif.ov_ts_submit_addr), 0);
    chk("rst_idx", int'(slot_idx), 0);
    chk("rst_miss", int'(miss), 0);
    chk_stats("rst");
    rst = 1'b0;

    for (int run = 0; run < 5; run++) begin
      slen = (run == 0) ? 16'd3 : 16'($urandom_range(0, 12));
      L = (slen < 16'd8) ? 8 : int'(slen);
      N = $urandom_range(2, 5);
      last = 10'(N - 1);
      kend = 2 * N + $urandom_range(0, N - 1);
      P = kend * L + 5;
      for (int i = 0; i < N; i++) begin
        tv[i] = 1'($urandom_range(0, 3) != 0);
        ta[i] = 5'($urandom);
      end
      tv[kend % N] = 1'b1;
      for (int i = 0; i < 64; i++) dl[i] = $urandom_range(0, L - 2);
      dl[kend] = L - 3;
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        twr = 1'b1; waddr = 10'(i); wdata = {tv[i], ta[i]};
      end
      @(negedge clk);
      twr = 1'b0;
      for (int p = 0; p <= P; p++) begin
        @(negedge clk);
        k = p / L; ph = p % L; s = k % N;
        ps = (k + N - 1) % N;
        km1 = (k > 0) ? k - 1 : 0;
        hold = tv[s] && ph >= 4 && ph <= 4 + dl[k];
        hang = k >= 1 && tv[ps] && 4 + dl[km1] >= L;
        e_wr = hold || (ph == 0 && hang);
        e_addr = hold ? int'(ta[s]) : int'(ta[ps]);
        e_miss = ph == 1 && hang && 4 + dl[km1] > L;
        ak = (tv[s] && ph == 4 + dl[k] && 4 + dl[k] < L)
          || (ph == 0 && hang && 4 + dl[km1] == L);
        chk($sformatf("r%0d_wr@%0d", run, p),
            int'(sif.o_ts_submit_addr_wr), int'(e_wr));
        if (e_wr)
          chk($sformatf("r%0d_addr@%0d", run, p),
              int'(sif.ov_ts_submit_addr), e_addr);
        chk($sformatf("r%0d_miss@%0d", run, p), int'(miss), int'(e_miss));
        chk($sformatf("r%0d_idx@%0d", run, p), int'(slot_idx), k % N);
        if (e_miss) exp_miss++;
        if (p < P && ak) exp_sub++;
        if (!ak && ph >= 1 && (ph <= 3 || !tv[s]))
          ak = ($urandom_range(0, 3) == 0);
        en = (p < P);
        sif.i_ts_submit_addr_ack = (p < P) && ak;
      end
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        chk($sformatf("r%0d_off_wr%0d", run, j),
            int'(sif.o_ts_submit_addr_wr), 0);
        chk($sformatf("r%0d_off_miss%0d", run, j), int'(miss), 0);
        chk($sformatf("r%0d_off_idx%0d", run, j), int'(slot_idx), 0);
      end
      chk_stats($sformatf("r%0d", run));
    end

    slen = 16'd8; last = 10'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      twr = 1'b1; waddr = 10'(i);
      wdata = (i == 0) ? 6'h29 : 6'h00;
    end
    @(negedge clk);
    twr = 1'b0;
    for (int p = 0; p <= 62; p++) begin
      @(negedge clk);
      e_idx = (p < 22) ? (p / 8) % 4 : ((p - 22) / 8) % 4;
      e_wr = (p >= 4 && p <= 8) || p == 26 || (p >= 58 && p <= 59);
      e_addr = (p >= 58) ? 12 : 9;
      chk($sformatf("d_wr@%0d", p),
          int'(sif.o_ts_submit_addr_wr), int'(e_wr));
      if (e_wr)
        chk($sformatf("d_addr@%0d", p), int'(sif.ov_ts_submit_addr), e_addr);
      chk($sformatf("d_miss@%0d", p), int'(miss), int'(p == 9));
      chk($sformatf("d_idx@%0d", p), int'(slot_idx), e_idx);
      en = (p < 62);
      cstart = (p == 21);
      sif.i_ts_submit_addr_ack = (p == 26) || (p == 59);
      twr = (p == 23);
      waddr = '0;
      wdata = 6'h2C;
    end
    exp_sub += 2;
    exp_miss += 1;
    @(negedge clk);
    chk("d_off_wr", int'(sif.o_ts_submit_addr_wr), 0);
    chk("d_off_idx", int'(slot_idx), 0);
    chk_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
